csa_resolver: RTL
=================

Name: csa_resolver

Overview:
- Carry-propagate stage placed directly downstream of the 32-bit carry-save adder.
- Takes one partial-sum/partial-carry pair per transaction and resolves it to a binary word, adding CHUNK bits per clock.
- Uses valid/ready handshakes on both sides, so it can sit between the CSA tree and the PE writeback or accumulator register.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CHUNK, 8: bits resolved per BUSY cycle. WIDTH must be an integer multiple of CHUNK; otherwise elaboration fails with $error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  ps/pc pair is valid
- in_ready  output  1  block can accept a pair
- ps  input  WIDTH  partial sum from the CSA
- pc  input  WIDTH  partial carry from the CSA, unshifted, weight 2^(i+1) per bit i
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  (ps + {pc[WIDTH-2:0],1'b0}) mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1 from that same addition; pc[WIDTH-1] is discarded and never affects cout

Behaviour:
- Reset: one clock, clk; reset rst is asynchronous and active-high. While rst=1:
  - state=IDLE, in_ready=0, out_valid=0, result=0, cout=0, internal chunk counter=0, carry register=0.
  - in_ready rises on the first clk edge after rst deasserts.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&in_ready, capture ps and {pc[WIDTH-2:0],0} into operand registers, clear the carry register and counter, go to BUSY.
  - BUSY: in_ready=0. Each cycle, add chunk k of both operands plus the carry register, write the sum into result[k*CHUNK +: CHUNK], and store the chunk carry-out. Increment k. When k reaches WIDTH/CHUNK-1, latch the final carry into cout and go to DONE.
  - DONE: out_valid=1, result and cout held stable. On out_ready=1, go to IDLE.
- Latency: a handshake at edge 0 gives out_valid=1 after edge WIDTH/CHUNK; this is 4 cycles for the defaults.
- Throughput: one transaction per WIDTH/CHUNK+2 cycles. There is no overlap between transactions.
- Backpressure: DONE holds indefinitely while out_ready=0, with result and cout unchanged. in_ready stays 0 until return to IDLE.
- Inputs are ignored outside IDLE; ps and pc may change freely after capture.
- in_valid must not depend combinationally on in_ready. out_valid is a registered output.
- result is partially updated in BUSY. Consumers sample it only when out_valid=1.
- Reset asserted mid-BUSY or mid-DONE aborts the transaction with no output handshake, and all outputs return to reset values immediately.
- Arithmetic is unsigned modular. cout gives the unsigned carry for the consumer's 33-bit use.

Optional Feature:
- Macro: CSA_RESOLVER_FAST_EN
- Defined: BUSY performs the full WIDTH-bit addition in a single cycle. out_valid rises on the edge after the accept edge (latency 1), and CHUNK is ignored.
- Undefined: chunked behaviour as specified above.
- The port list is identical in both builds.

Test Plan:
- Basic add: reset, then ps=0x00000005, pc=0x00000003, out_ready=1 → result=0x0000000B, cout=0. out_valid rises exactly 4 cycles after accept (1 cycle with FAST_EN).
- Cross-chunk carry: ps=0x000000FF, pc=0x00000001 → result=0x00000101, cout=0. Also ps=0x00FFFFFF, pc=0x00000001 → result=0x01000001.
- Wrap and carry-out: ps=0xFFFFFFFF, pc=0x00000001 → result=0x00000001, cout=1. Also ps=0x00000000, pc=0x80000000 → result=0x00000000, cout=0 (pc[31] dropped).
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid → result and cout stable, in_ready=0, a second in_valid is not accepted.
  - Release out_ready → IDLE next cycle, and the queued pair is accepted on the following edge.
- Reset mid-operation: accept ps=0x12345678, pc=0x11111111, assert rst during the second BUSY cycle → out_valid, result and cout go to 0 asynchronously before the next clk edge. After release, ps=0x1, pc=0x1 yields result=0x00000003.
- Random regression: 1000 random ps/pc pairs with random out_ready stalls, in both macro builds → every result and cout matches a reference model of ps+(pc<<1). Exactly one output per accepted input, in order.

Source files
------------

// File: rtl/csa_resolver_if.sv
// Valid/ready bundle linking the CSA tree, csa_resolver and its result consumer.
// master drives operands and out_ready; slave is the resolver side.
interface csa_resolver_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] ps;
    logic [WIDTH-1:0] pc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;

    modport master (
        output in_valid, ps, pc, out_ready,
        input  in_ready, out_valid, result, cout
    );

    modport slave (
        input  in_valid, ps, pc, out_ready,
        output in_ready, out_valid, result, cout
    );
endinterface

// File: rtl/csa_resolver.sv
// Carry-propagate stage behind the CSA: resolves ps + (pc << 1) CHUNK bits per cycle.
// Define CSA_RESOLVER_FAST_EN to resolve the whole word in one BUSY cycle instead.
module csa_resolver #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic          clk,
    input  logic          rst,
    csa_resolver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             in_ready_q;
    logic             out_valid_q;

`ifndef CSA_RESOLVER_FAST_EN
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] lsb_c;
    logic [CHUNK:0]   sum_c;

    if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
        $error("csa_resolver: WIDTH must be an integer multiple of CHUNK");
    end
`endif

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cout_d  = cout_q;
`ifndef CSA_RESOLVER_FAST_EN
        cnt_d   = cnt_q;
        carry_d = carry_q;
        lsb_c   = IDX_W'(cnt_q) * IDX_W'(CHUNK);
        sum_c   = {1'b0, a_q[lsb_c +: CHUNK]} + {1'b0, b_q[lsb_c +: CHUNK]}
                + {{CHUNK{1'b0}}, carry_q};
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.ps;
                    b_d     = {bus.pc[WIDTH-2:0], 1'b0};
`ifndef CSA_RESOLVER_FAST_EN
                    cnt_d   = '0;
                    carry_d = 1'b0;
`endif
                    state_d = BUSY;
                end
            end
            BUSY: begin
`ifdef CSA_RESOLVER_FAST_EN
                {cout_d, res_d} = {1'b0, a_q} + {1'b0, b_q};
                state_d         = DONE;
`else
                res_d[lsb_c +: CHUNK] = sum_c[CHUNK-1:0];
                carry_d               = sum_c[CHUNK];
                cnt_d                 = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NCHUNK - 1)) begin
                    cout_d  = sum_c[CHUNK];
                    cnt_d   = '0;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they track it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifndef CSA_RESOLVER_FAST_EN
            cnt_q       <= '0;
            carry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            cout_q      <= cout_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
`ifndef CSA_RESOLVER_FAST_EN
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;
    assign bus.cout      = cout_q;
endmodule
